// File: rtl/imm_encoder_if.sv
// Handshake bus for imm_encoder: valid/ready input side, valid/ready output side.
// The design sits on the slave modport, the producer/consumer on master.
interface imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  enc_sel;
   logic [31:0] imm_in;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] imm_out;
   logic [2:0]  out_sel;
   logic        err;
   logic [7:0]  err_cnt;

   modport master (
      output in_valid, enc_sel, imm_in, out_ready,
      input  in_ready, out_valid, imm_out, out_sel, err, err_cnt
   );

   modport slave (
      input  in_valid, enc_sel, imm_in, out_ready,
      output in_ready, out_valid, imm_out, out_sel, err, err_cnt
   );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage pipelined RISC-V immediate encoder: scatters a 32-bit immediate into
// instruction bits [31:7] for I/S/B/U/J formats and flags non-encodable values.
module imm_encoder (
   input logic          clk,
   input logic          rst,
   imm_encoder_if.slave bus
);
   localparam logic [2:0] SEL_I = 3'b000;
   localparam logic [2:0] SEL_S = 3'b001;
   localparam logic [2:0] SEL_B = 3'b010;
   localparam logic [2:0] SEL_U = 3'b011;
   localparam logic [2:0] SEL_J = 3'b100;

   logic        s1_valid;
   logic [2:0]  s1_sel;
   logic [31:0] s1_imm;
   logic        s2_valid;
   logic [24:0] s2_imm;
   logic [2:0]  s2_sel;
   logic        s2_err;
   logic [7:0]  err_cnt;
   logic        advance;
   logic        in_fire;
   logic        out_fire;
   logic [24:0] enc_imm;
   logic        enc_err;

   assign out_fire      = s2_valid && bus.out_ready;
   assign advance       = !s2_valid || bus.out_ready;
   assign bus.in_ready  = !rst && (!s1_valid || advance);
   assign in_fire       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = s2_valid;
   assign bus.imm_out   = s2_imm;
   assign bus.out_sel   = s2_sel;
   assign bus.err       = s2_err;
   assign bus.err_cnt   = err_cnt;

   // Field scatter plus legality; mapping is kept even when err is set.
   always_comb begin
      enc_imm = '0;
      enc_err = 1'b1;
      case (s1_sel)
         SEL_I: begin
            enc_imm[24:13] = s1_imm[11:0];
            enc_err        = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
         end
         SEL_S: begin
            enc_imm[24:18] = s1_imm[11:5];
            enc_imm[4:0]   = s1_imm[4:0];
            enc_err        = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
         end
         SEL_B: begin
            enc_imm[24]    = s1_imm[12];
            enc_imm[23:18] = s1_imm[10:5];
            enc_imm[4:1]   = s1_imm[4:1];
            enc_imm[0]     = s1_imm[11];
            enc_err        = !(((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0]);
         end
         SEL_U: begin
            enc_imm[24:5]  = s1_imm[31:12];
            enc_err        = |s1_imm[11:0];
         end
         SEL_J: begin
            enc_imm[24]    = s1_imm[20];
            enc_imm[23:14] = s1_imm[10:1];
            enc_imm[13]    = s1_imm[11];
            enc_imm[12:5]  = s1_imm[19:12];
            enc_err        = !(((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0]);
         end
         default: begin
            enc_imm = '0;
            enc_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sel   <= '0;
         s1_imm   <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_sel   <= bus.enc_sel;
         s1_imm   <= bus.imm_in;
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   // Output data only reloads when a real item moves in, so a stalled item holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_imm   <= '0;
         s2_sel   <= '0;
         s2_err   <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_imm <= enc_imm;
            s2_sel <= s1_sel;
            s2_err <= enc_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (out_fire && s2_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. All state SHALL clear immediately on rst=1, independent of clk.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit: an input item is offered.
REQ-005 Port in_ready, output, 1 bit: the block accepts the offered item this cycle.
REQ-006 Port enc_sel, input, 3 bits: immediate format. 000=I, 001=S, 010=B, 011=U, 100=J; 101-111 are illegal.
REQ-007 Port imm_in, input, 32 bits: the 32-bit immediate value to encode.
REQ-008 Port out_valid, output, 1 bit: imm_out, err and out_sel are valid.
REQ-009 Port out_ready, input, 1 bit: the downstream consumer accepts the output this cycle.
REQ-010 Port imm_out, output, 25 bits: the encoded value, equal to instruction bits [31:7].
REQ-011 Port out_sel, output, 3 bits: the enc_sel value carried with this item.
REQ-012 Port err, output, 1 bit: this item is not exactly encodable (range, alignment or illegal format).
REQ-013 Port err_cnt, output, 8 bits: saturating count of error items delivered.

Function
REQ-014 The datapath SHALL be a two-stage pipeline.
- Stage 1 registers enc_sel and imm_in and computes legality.
- Stage 2 registers imm_out, out_sel and err.
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1. An output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 The pipeline SHALL advance only when the stage-2 register is empty or an output transfer occurs.
- in_ready = !stage1_full OR advance.
- Stage 1 SHALL pass to stage 2 on advance.
REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput SHALL be 1 item per cycle.
REQ-018 While out_valid=1 and out_ready=0, imm_out, out_sel and err SHALL remain stable. No item SHALL be dropped or duplicated, and item order SHALL be preserved.
REQ-019 Every imm_out bit not listed for a format SHALL be 0.
REQ-020 I format: imm_out[24:13]=imm_in[11:0]. err=1 unless imm_in[31:11] are all equal.
REQ-021 S format: imm_out[24:18]=imm_in[11:5] and imm_out[4:0]=imm_in[4:0]. err=1 unless imm_in[31:11] are all equal.
REQ-022 B format: imm_out[24]=imm_in[12], [23:18]=imm_in[10:5], [4:1]=imm_in[4:1], [0]=imm_in[11]. err=1 unless imm_in[31:12] are all equal AND imm_in[0]=0.
REQ-023 U format: imm_out[24:5]=imm_in[31:12]. err=1 unless imm_in[11:0]=0.
REQ-024 J format: imm_out[24]=imm_in[20], [23:14]=imm_in[10:1], [13]=imm_in[11], [12:5]=imm_in[19:12]. err=1 unless imm_in[31:20] are all equal AND imm_in[0]=0.
REQ-025 For an illegal enc_sel: imm_out=0 and err=1.
REQ-026 When err=1 for a legal format, imm_out SHALL still carry the truncated field mapping from REQ-020 to REQ-024.
REQ-027 Round-trip property: for any item with err=0, sign-extending (imm_out, out_sel) under the team's immediate decode rules SHALL reproduce imm_in exactly.
REQ-028 err_cnt SHALL increment by 1 on each output transfer with err=1 and SHALL saturate at 0xFF without wrapping.
REQ-029 Simultaneous input and output transfers in one cycle SHALL both complete. Occupancy SHALL then be unchanged.

Reset
REQ-030 On rst=1 the block SHALL drive out_valid=0, in_ready=0, imm_out=0, out_sel=0, err=0 and err_cnt=0, and SHALL clear both stage-valid flags.
REQ-031 in_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-032 Items in flight when reset asserts SHALL be discarded. No output transfer SHALL occur for them after reset.

Verification
REQ-033 I format, imm_in=0xFFFFF800, no backpressure -> 2 cycles later out_valid=1, imm_out=0x1000000, err=0.
REQ-034 I format, imm_in=0x00000800 -> imm_out=0x1000000, err=1, and err_cnt goes 0->1 on the transfer.
REQ-035 B format, imm_in=0x00000FFE -> imm_out=0x0FC001F, err=0. B format, imm_in=0x00000FFF -> err=1 (misaligned).
REQ-036 U format, imm_in=0x12345000 -> imm_out=0x02468A0, err=0. J format, imm_in=0x00100000 -> err=1 (range).
REQ-037 Backpressure: feed 4 back-to-back items while out_ready=0 for 3 cycles -> in_ready=0 once both stages are full, output held stable, all 4 items delivered in order after out_ready=1.
REQ-038 Reset: assert rst with 2 items in flight and err_cnt=5 -> out_valid=0 and err_cnt=0 at once; the items never appear; in_ready=1 in the cycle after release.
